// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Field bit positions are also used by decoder_unit.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_REQ,
        S_ISSUE,
        S_FAULT
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'hE1A0_0000;

    localparam int unsigned COND_HI  = 31;
    localparam int unsigned COND_LO  = 28;
    localparam int unsigned OP_HI    = 27;
    localparam int unsigned OP_LO    = 26;
    localparam int unsigned FUNCT_HI = 25;
    localparam int unsigned FUNCT_LO = 20;
    localparam int unsigned RD_HI    = 15;
    localparam int unsigned RD_LO    = 12;
    localparam int unsigned SH_HI    = 6;
    localparam int unsigned SH_LO    = 5;

endpackage

// File: rtl/pc_reg.sv
// Program counter with next-PC selection and a registered misaligned-branch pulse.
module pc_reg #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_en,
    input  logic        pc_src,
    input  logic [31:0] branch_target,
    output logic [31:0] pc,
    output logic        align_err
);

    logic [31:0] pc_d, pc_q;
    logic        align_err_d, align_err_q;

    always_comb begin
        pc_d        = pc_q;
        align_err_d = 1'b0;
        if (load_en) begin
            pc_d        = pc_src ? {branch_target[31:2], 2'b00} : pc_q + 32'd4;
            align_err_d = pc_src && (branch_target[1:0] != 2'b00);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q        <= RESET_PC;
            align_err_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            align_err_q <= align_err_d;
        end
    end

    assign pc        = pc_q;
    assign align_err = align_err_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem req/ack handshake, instruction register,
// timeout watchdog and retired-instruction counter.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    input  logic             stall,
    input  logic             pc_src,
    input  logic [31:0]      branch_target,
    output logic [31:0]      instr,
    output logic             instr_valid,
    output logic [3:0]       cond,
    output logic [1:0]       op,
    output logic [5:0]       funct,
    output logic [3:0]       rd,
    output logic [1:0]       sh,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus8,
    output logic             align_err,
    output logic             fault,
    output logic [CNT_W-1:0] retired
);

    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

    fetch_state_t     state_d, state_q;
    logic             req_d, req_q;
    logic [31:0]      instr_d, instr_q;
    logic             valid_d, valid_q;
    logic             fault_d, fault_q;
    logic [CNT_W-1:0] retired_d, retired_q;
    logic [TO_W-1:0]  to_cnt_d, to_cnt_q;
    logic             advance;

    // S_REQ is entered from reset with req_q low; the first cycle only raises
    // the request, so acks arriving then are treated as stale.
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        instr_d   = instr_q;
        valid_d   = valid_q;
        fault_d   = fault_q;
        retired_d = retired_q;
        to_cnt_d  = to_cnt_q;
        advance   = 1'b0;
        case (state_q)
            S_REQ: begin
                if (!req_q) begin
                    req_d = 1'b1;
                end else if (imem_ack) begin
                    instr_d = imem_rdata;
                    valid_d = 1'b1;
                    req_d   = 1'b0;
                    state_d = S_ISSUE;
                end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                    to_cnt_d = TO_W'(TIMEOUT);
                    fault_d  = 1'b1;
                    req_d    = 1'b0;
                    state_d  = S_FAULT;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            S_ISSUE: begin
                if (!stall) begin
                    advance   = 1'b1;
                    valid_d   = 1'b0;
                    retired_d = retired_q + CNT_W'(1);
                    to_cnt_d  = '0;
                    req_d     = 1'b1;
                    state_d   = S_REQ;
                end
            end
            S_FAULT: begin
                req_d   = 1'b0;
                valid_d = 1'b0;
            end
            default: begin
                req_d   = 1'b0;
                state_d = S_REQ;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_REQ;
            req_q     <= 1'b0;
            instr_q   <= NOP_INSTR;
            valid_q   <= 1'b0;
            fault_q   <= 1'b0;
            retired_q <= '0;
            to_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            instr_q   <= instr_d;
            valid_q   <= valid_d;
            fault_q   <= fault_d;
            retired_q <= retired_d;
            to_cnt_q  <= to_cnt_d;
        end
    end

    pc_reg #(
        .RESET_PC(RESET_PC)
    ) u_pc_reg (
        .clk           (clk),
        .rst           (rst),
        .load_en       (advance),
        .pc_src        (pc_src),
        .branch_target (branch_target),
        .pc            (pc),
        .align_err     (align_err)
    );

    assign imem_req    = req_q;
    assign imem_addr   = pc;
    assign pc_plus8    = pc + 32'd8;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign fault       = fault_q;
    assign retired     = retired_q;

    assign cond  = instr_q[COND_HI:COND_LO];
    assign op    = instr_q[OP_HI:OP_LO];
    assign funct = instr_q[FUNCT_HI:FUNCT_LO];
    assign rd    = instr_q[RD_HI:RD_LO];
    assign sh    = instr_q[SH_HI:SH_LO];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle vector table for the sequential
// fetch stream, hand-written sequences for stall, branch, timeout and reset.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        pc_src;
    logic [31:0] branch_target;
    logic [31:0] instr;
    logic        instr_valid;
    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rd;
    logic [1:0]  sh;
    logic [31:0] pc;
    logic [31:0] pc_plus8;
    logic        align_err;
    logic        fault;
    logic [31:0] retired;

    int unsigned total  = 0;
    int unsigned passed = 0;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC(32'h0000_0000),
        .TIMEOUT (16),
        .CNT_W   (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .pc_src        (pc_src),
        .branch_target (branch_target),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .cond          (cond),
        .op            (op),
        .funct         (funct),
        .rd            (rd),
        .sh            (sh),
        .pc            (pc),
        .pc_plus8      (pc_plus8),
        .align_err     (align_err),
        .fault         (fault),
        .retired       (retired)
    );

    typedef struct {
        logic        ack;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_ret;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            passed++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        vecs[0]  = '{1'b0, 32'h0,         1'b1, 32'h00, 1'b0, 32'hE1A0_0000, 32'd0};
        vecs[1]  = '{1'b1, 32'hA5A5_0000, 1'b1, 32'h00, 1'b0, 32'hE1A0_0000, 32'd0};
        vecs[2]  = '{1'b0, 32'h0,         1'b0, 32'h00, 1'b1, 32'hA5A5_0000, 32'd0};
        vecs[3]  = '{1'b0, 32'h0,         1'b1, 32'h04, 1'b0, 32'hA5A5_0000, 32'd1};
        vecs[4]  = '{1'b1, 32'hA5A5_0004, 1'b1, 32'h04, 1'b0, 32'hA5A5_0000, 32'd1};
        vecs[5]  = '{1'b0, 32'h0,         1'b0, 32'h04, 1'b1, 32'hA5A5_0004, 32'd1};
        vecs[6]  = '{1'b0, 32'h0,         1'b1, 32'h08, 1'b0, 32'hA5A5_0004, 32'd2};
        vecs[7]  = '{1'b1, 32'hA5A5_0008, 1'b1, 32'h08, 1'b0, 32'hA5A5_0004, 32'd2};
        vecs[8]  = '{1'b0, 32'h0,         1'b0, 32'h08, 1'b1, 32'hA5A5_0008, 32'd2};
        vecs[9]  = '{1'b0, 32'h0,         1'b1, 32'h0C, 1'b0, 32'hA5A5_0008, 32'd3};
        vecs[10] = '{1'b1, 32'hA5A5_000C, 1'b1, 32'h0C, 1'b0, 32'hA5A5_0008, 32'd3};
        vecs[11] = '{1'b0, 32'h0,         1'b0, 32'h0C, 1'b1, 32'hA5A5_000C, 32'd3};
        vecs[12] = '{1'b0, 32'h0,         1'b1, 32'h10, 1'b0, 32'hA5A5_000C, 32'd4};

        rst = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
        stall = 1'b0; pc_src = 1'b0; branch_target = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req",     {31'b0, imem_req},    32'd0);
        chk("rst_pc",      pc,                   32'h0000_0000);
        chk("rst_instr",   instr,                32'hE1A0_0000);
        chk("rst_valid",   {31'b0, instr_valid}, 32'd0);
        chk("rst_fault",   {31'b0, fault},       32'd0);
        chk("rst_retired", retired,              32'd0);
        chk("rst_align",   {31'b0, align_err},   32'd0);
        chk("rst_cond",    {28'b0, cond},        32'hE);
        chk("rst_funct",   {26'b0, funct},       32'h1A);
        #2 rst = 1'b1;
        chk("post_rel_req", {31'b0, imem_req}, 32'd0);
        tick();

        // Sequential fetch stream with one-cycle ack latency
        for (int i = 0; i < 13; i++) begin
            imem_ack   = vecs[i].ack;
            imem_rdata = vecs[i].rdata;
            chk($sformatf("v%0d_req", i),   {31'b0, imem_req},    {31'b0, vecs[i].e_req});
            chk($sformatf("v%0d_addr", i),  imem_addr,            vecs[i].e_addr);
            chk($sformatf("v%0d_valid", i), {31'b0, instr_valid}, {31'b0, vecs[i].e_valid});
            chk($sformatf("v%0d_instr", i), instr,                vecs[i].e_instr);
            chk($sformatf("v%0d_ret", i),   retired,              vecs[i].e_ret);
            chk($sformatf("v%0d_pc8", i),   pc_plus8,             vecs[i].e_addr + 32'd8);
            tick();
        end

        imem_ack = 1'b1; imem_rdata = 32'hA5A5_0010;
        tick();
        imem_ack = 1'b0;
        chk("f10_valid", {31'b0, instr_valid}, 32'd1);
        chk("f10_instr", instr, 32'hA5A5_0010);

        // Stall holds everything; pc_src toggles and a stray ack are ignored
        for (int i = 0; i < 5; i++) begin
            stall = 1'b1; pc_src = i[0]; branch_target = 32'h0000_0200;
            imem_ack = (i == 2); imem_rdata = 32'hDEAD_BEEF;
            tick();
            chk($sformatf("stall%0d_pc", i),    pc,                   32'h10);
            chk($sformatf("stall%0d_instr", i), instr,                32'hA5A5_0010);
            chk($sformatf("stall%0d_valid", i), {31'b0, instr_valid}, 32'd1);
            chk($sformatf("stall%0d_req", i),   {31'b0, imem_req},    32'd0);
        end
        stall = 1'b0; pc_src = 1'b0; imem_ack = 1'b0;
        tick();
        chk("unstall_addr", imem_addr, 32'h14);
        chk("unstall_req",  {31'b0, imem_req}, 32'd1);
        chk("unstall_ret",  retired, 32'd5);

        // Same-cycle ack, field slicing, misaligned branch
        imem_ack = 1'b1; imem_rdata = 32'h6D2B_A7C4;
        tick();
        imem_ack = 1'b0;
        chk("fld_instr", instr, 32'h6D2B_A7C4);
        chk("fld_cond",  {28'b0, cond},  32'h6);
        chk("fld_op",    {30'b0, op},    32'h3);
        chk("fld_funct", {26'b0, funct}, 32'h12);
        chk("fld_rd",    {28'b0, rd},    32'hA);
        chk("fld_sh",    {30'b0, sh},    32'h2);
        pc_src = 1'b1; branch_target = 32'h0000_0102;
        chk("br_align_pre", {31'b0, align_err}, 32'd0);
        tick();
        pc_src = 1'b0;
        chk("br_addr",  imem_addr, 32'h100);
        chk("br_align", {31'b0, align_err}, 32'd1);
        chk("br_ret",   retired, 32'd6);
        tick();
        chk("br_align_drop", {31'b0, align_err}, 32'd0);
        chk("br_req",        {31'b0, imem_req},  32'd1);

        // Aligned branch to top of memory, ack during issue ignored, PC wrap
        imem_ack = 1'b1; imem_rdata = 32'h0;
        tick();
        pc_src = 1'b1; branch_target = 32'hFFFF_FFFC; imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ack = 1'b0; pc_src = 1'b0;
        chk("top_addr",  imem_addr, 32'hFFFF_FFFC);
        chk("top_pc8",   pc_plus8,  32'h0000_0004);
        chk("top_align", {31'b0, align_err}, 32'd0);
        chk("top_instr", instr, 32'h0);
        imem_ack = 1'b1; imem_rdata = 32'h1111_1111;
        tick();
        imem_ack = 1'b0;
        tick();
        chk("wrap_addr", imem_addr, 32'h0);
        chk("wrap_ret",  retired,   32'd8);
        imem_ack = 1'b1; imem_rdata = 32'h2222_2222;
        tick();
        imem_ack = 1'b0;
        tick();
        chk("pre_to_addr", imem_addr, 32'h4);

        // Timeout: 16 unacknowledged request cycles then fault
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("to%0d_fault", i), {31'b0, fault},    32'd0);
            chk($sformatf("to%0d_req", i),   {31'b0, imem_req}, 32'd1);
            tick();
        end
        chk("to_fault", {31'b0, fault},       32'd1);
        chk("to_req",   {31'b0, imem_req},    32'd0);
        chk("to_valid", {31'b0, instr_valid}, 32'd0);
        imem_ack = 1'b1; imem_rdata = 32'h9999_9999;
        repeat (2) tick();
        imem_ack = 1'b0;
        chk("to_sticky", {31'b0, fault},    32'd1);
        chk("to_noreq",  {31'b0, imem_req}, 32'd0);

        // Reset clears fault and restarts at RESET_PC; stale ack ignored
        rst = 1'b0;
        #1;
        chk("fr_fault", {31'b0, fault},    32'd0);
        chk("fr_req",   {31'b0, imem_req}, 32'd0);
        chk("fr_pc",    pc,                32'h0);
        chk("fr_ret",   retired,           32'd0);
        tick();
        rst = 1'b1;
        imem_ack = 1'b1; imem_rdata = 32'h3333_3333;
        tick();
        imem_ack = 1'b0;
        chk("fr_req_up", {31'b0, imem_req},    32'd1);
        chk("fr_addr",   imem_addr,            32'h0);
        chk("fr_stale",  instr,                32'hE1A0_0000);
        chk("fr_valid",  {31'b0, instr_valid}, 32'd0);

        // Reset mid-request: req drops at once, ack during reset not captured
        rst = 1'b0;
        #1;
        chk("mr_req_drop", {31'b0, imem_req}, 32'd0);
        imem_ack = 1'b1; imem_rdata = 32'h4444_4444;
        repeat (2) tick();
        chk("mr_instr", instr, 32'hE1A0_0000);
        chk("mr_valid", {31'b0, instr_valid}, 32'd0);
        rst = 1'b1;
        tick();
        imem_ack = 1'b0;
        chk("mr_req",   {31'b0, imem_req},    32'd1);
        chk("mr_addr",  imem_addr,            32'h0);
        chk("mr_valid2", {31'b0, instr_valid}, 32'd0);
        chk("mr_instr2", instr,               32'hE1A0_0000);
        imem_ack = 1'b1; imem_rdata = 32'h5555_5555;
        tick();
        imem_ack = 1'b0;
        chk("mr_cap_valid", {31'b0, instr_valid}, 32'd1);
        chk("mr_cap_instr", instr,                32'h5555_5555);
        chk("mr_cap_ret",   retired,              32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage directly upstream of the ARM-style control unit and datapath. It holds the PC, requests instruction words from instruction memory over a req/ack handshake, and registers each returned word. It presents the word and its pre-sliced decode fields (cond/op/funct/rd/sh) to the control unit, then advances the PC using the pc_src/branch target the control unit and datapath return. It also provides a memory timeout watchdog and a retired-instruction counter.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
TIMEOUT, 16, max cycles imem_req may stay unacknowledged before fault
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
imem_req  out  1  fetch request to instruction memory
imem_addr  out  32  word-aligned fetch address (= pc)
imem_ack  in  1  memory returns imem_rdata this cycle
imem_rdata  in  32  instruction word
stall  in  1  hold current instruction in issue
pc_src  in  1  1 = take branch_target, 0 = pc+4
branch_target  in  32  next PC when pc_src=1
instr  out  32  registered instruction
instr_valid  out  1  instr and fields valid for decode
cond  out  4  instr[31:28]
op  out  2  instr[27:26]
funct  out  6  instr[25:20]
rd  out  4  instr[15:12]
sh  out  2  instr[6:5]
pc  out  32  address of instr
pc_plus8  out  32  pc+8, the architectural R15 read value
align_err  out  1  one-cycle pulse: branch_target[1:0]!=0 when taken
fault  out  1  sticky: imem timeout
retired  out  CNT_W  instructions issued and advanced

Behaviour:
- Reset (rst=0, async): state=S_REQ, pc=RESET_PC, instr=NOP (32'hE1A0_0000), instr_valid=0, imem_req=0, align_err=0, fault=0, retired=0, timeout counter=0. imem_req is low while rst=0 and rises the first cycle after release.
- States: S_REQ, S_ISSUE, S_FAULT.
- S_REQ: imem_req=1, imem_addr=pc. On imem_ack=1: instr<=imem_rdata, instr_valid<=1, go to S_ISSUE next edge. A same-cycle ack is legal, so the minimum is 2 cycles per instruction.
- Timeout: counter increments each S_REQ cycle without ack. When it reaches TIMEOUT, go to S_FAULT and set fault=1. In S_FAULT, imem_req=0 and instr_valid=0. Only reset exits S_FAULT.
- S_ISSUE: imem_req=0, instr_valid=1.
  - stall=1: hold all state. pc_src is ignored.
  - stall=0: pc <= pc_src ? {branch_target[31:2],2'b00} : pc+4. retired increments (wraps at 2^CNT_W). instr_valid<=0. Timeout counter cleared. Go to S_REQ.
- align_err pulses in that same advancing cycle if pc_src=1 and branch_target[1:0]!=0. The low bits are forced to zero.
- Field outputs are combinational slices of the instr register and are always driven. Downstream qualifies them with instr_valid.
- PC arithmetic: modulo 2^32, so 32'hFFFF_FFFC+4 wraps to 0. pc_plus8 is combinational pc+8, also modulo.
- imem_ack outside S_REQ is ignored, including stale acks after reset.
- Reset mid-request: imem_req drops immediately and asynchronously. No partial capture occurs.

Decomposition:
- Package fetch_pkg:
  - state enum fetch_state_t {S_REQ,S_ISSUE,S_FAULT}
  - NOP_INSTR constant
  - field bit-position localparams shared with decoder_unit
- One natural sub-module: pc_reg (PC register with async active-low reset, load-enable, next-PC mux, alignment check). FSM, counters and instr register stay in fetch_unit.

Test Plan:
- Reset then memory acks each req after 1 cycle with rdata=addr^32'hA5A5_0000, stall=0, pc_src=0 -> imem_addr sequence 0,4,8,C. Each instr matches. retired=4 after 4 issues. pc_plus8=pc+8.
- In S_ISSUE, hold stall=1 for 5 cycles with pc_src toggling -> pc, instr, instr_valid unchanged and no imem_req. Releasing stall with pc_src=0 advances to pc+4.
- Issue with pc_src=1, branch_target=32'h0000_0102 -> next imem_addr=32'h0000_0100. align_err high exactly one cycle.
- With TIMEOUT=16, never ack -> fault rises after 16 request cycles and imem_req falls. Asserting rst clears fault and restarts at RESET_PC.
- Assert rst mid-S_REQ, then ack while rst=0 -> nothing captured. After release, instr_valid=0 and fetch restarts at RESET_PC.
- Start at pc=32'hFFFF_FFFC with pc_src=0 -> next imem_addr=0. Also drive imem_ack during S_ISSUE -> ignored.
